// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM arbiter.
// Optional round-robin arbitration is enabled by defining MEM_ARB_RR_EN.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/arb_grant.sv
// arb_grant: 2-way grant picker for the fetch and data ports.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module arb_grant
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic       clock,
    input  logic       reset,
`endif
    input  logic       valid_f,
    input  logic       valid_d,
    input  logic       en,
    output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
    // prio_q names the port preferred on the next tie; fetch first after reset
    logic prio_q;
    logic prio_d;

    // pick a port, breaking ties with the round-robin pointer
    always_comb begin
        grant = '0;
        prio_d = prio_q;
        if (en) begin
            if (valid_f && valid_d) begin
                grant[prio_q] = 1'b1;
            end else begin
                grant[PORT_FETCH] = valid_f;
                grant[PORT_DATA]  = valid_d;
            end
        end
        if (|grant) begin
            prio_d = grant[PORT_DATA] ? PORT_FETCH : PORT_DATA;
        end
    end

    // pointer moves on every accept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= PORT_FETCH;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // fixed priority: data always wins a tie
    always_comb begin
        grant = '0;
        if (en) begin
            grant[PORT_DATA]  = valid_d;
            grant[PORT_FETCH] = valid_f && !valid_d;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration (default: data priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              f_valid,
    input  logic [ADDR_W-1:0] f_address,
    output logic              f_ready,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              d_valid,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_data_output,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    logic [1:0] grant;
    logic       accept_en;
    logic       accept;
    logic       resp;

    assign accept_en = ((state_q == IDLE) || (state_q == RESP)) && !reset;
    assign accept    = |grant;

    arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
        .clock   (clock),
        .reset   (reset),
`endif
        .valid_f (f_valid),
        .valid_d (d_valid),
        .en      (accept_en),
        .grant   (grant)
    );

    // next state, and latch of the accepted request into the RAM-side flops
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        wr_d          = wr_q;
        ram_read_d    = 1'b0;
        ram_write_d   = 1'b0;
        ram_address_d = '0;
        ram_data_d    = '0;

        unique case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = accept ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            owner_d       = grant[PORT_DATA] ? PORT_DATA : PORT_FETCH;
            wr_d          = grant[PORT_DATA] && d_write;
            ram_read_d    = !wr_d;
            ram_write_d   = wr_d;
            ram_address_d = grant[PORT_DATA] ? d_address : f_address;
            if (wr_d) begin
                ram_data_d = d_wdata;
            end
        end
    end

    // state and RAM-side registers; reset drops any transaction in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            owner_q       <= PORT_FETCH;
            wr_q          <= 1'b0;
            ram_read_q    <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_address_q <= '0;
            ram_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            wr_q          <= wr_d;
            ram_read_q    <= ram_read_d;
            ram_write_q   <= ram_write_d;
            ram_address_q <= ram_address_d;
            ram_data_q    <= ram_data_d;
        end
    end

    assign resp = (state_q == RESP);

    assign f_ready     = grant[PORT_FETCH];
    assign d_ready     = grant[PORT_DATA];
    assign f_rsp_valid = resp && (owner_q == PORT_FETCH);
    assign d_rsp_valid = resp && (owner_q == PORT_DATA);
    assign f_rsp_data  = f_rsp_valid ? ram_data_output : '0;
    assign d_rsp_data  = (d_rsp_valid && !wr_q) ? ram_data_output : '0;

    assign ram_read    = ram_read_q;
    assign ram_write   = ram_write_q;
    assign ram_address = ram_address_q;
    assign ram_data    = ram_data_q;
    assign busy        = (state_q == ISSUE) || resp;

endmodule
